// File: rtl/trigger_sequencer.sv
// trigger_sequencer
//   Per-channel trigger controller in the FCLK domain. A qualified rising edge
//   of the synchronized trigger runs the sequence:
//   ARMED -> post-trigger DELAY -> STOPPED (one-cycle stop pulse, wait for
//   readout) -> HOLDOFF -> ARMED.
//   Accepted triggers are counted; the counter wraps modulo 2^CNT_W.
//
//   Optional feature macro: TRIG_FORCE_EN. When it is defined, the force_trig
//   port exists and acts as a software trigger that is only honoured in ARMED.
//
// Ports
//   FCLK          sampling-domain clock
//   RSTB          asynchronous active-low reset
//   trigger_sync  trigger level, already synchronized to FCLK
//   arm, disarm   single-cycle control pulses
//   delay_cfg     post-trigger delay (FCLK cycles), sampled at acceptance
//   holdoff_cfg   re-arm holdoff (FCLK cycles), sampled at readout_done
//   readout_done  single-cycle pulse from the readout logic
//   force_trig    software trigger (TRIG_FORCE_EN only)
//   sample_en     channel sampling enable
//   stop          one-cycle stop pulse to the sampling array
//   busy          high in DELAY, STOPPED and HOLDOFF
//   trig_count    accepted-trigger count
//   state         current state encoding
module trigger_sequencer #(
    parameter int DELAY_W   = 8,
    parameter int HOLDOFF_W = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 FCLK,
    input  logic                 RSTB,
    input  logic                 trigger_sync,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic [DELAY_W-1:0]   delay_cfg,
    input  logic [HOLDOFF_W-1:0] holdoff_cfg,
    input  logic                 readout_done,
`ifdef TRIG_FORCE_EN
    input  logic                 force_trig,
`endif
    output logic                 sample_en,
    output logic                 stop,
    output logic                 busy,
    output logic [CNT_W-1:0]     trig_count,
    output logic [2:0]           state
);

    // One down-counter is shared by DELAY and HOLDOFF.
    localparam int CW = (DELAY_W > HOLDOFF_W) ? DELAY_W : HOLDOFF_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_STOPPED = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_trig_d;
    logic             r_disarm_pend;
    logic             r_sample_en;
    logic             r_stop;
    logic             r_busy;
    logic [CNT_W-1:0] r_trig_count;

    state_t           w_nxt_state;
    logic [CW-1:0]    w_nxt_cnt;
    logic             w_nxt_pend;
    logic             w_accept;
    logic             w_rise;

    always_comb begin
        w_rise = trigger_sync & ~r_trig_d;
`ifdef TRIG_FORCE_EN
        // A coincident force and edge is still a single acceptance.
        w_accept = w_rise | force_trig;
`else
        w_accept = w_rise;
`endif
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_pend  = r_disarm_pend;
        case (r_state)
            S_IDLE: begin
                if (arm && !disarm) w_nxt_state = S_ARMED;
            end
            S_ARMED: begin
                if (disarm) begin
                    w_nxt_state = S_IDLE;
                end else if (w_accept) begin
                    if (delay_cfg == '0) begin
                        w_nxt_state = S_STOPPED;
                    end else begin
                        w_nxt_state = S_DELAY;
                        w_nxt_cnt   = CW'(delay_cfg) - CW'(1);
                    end
                end
            end
            S_DELAY: begin
                if (disarm)              w_nxt_state = S_IDLE;
                else if (r_cnt == '0)    w_nxt_state = S_STOPPED;
                else                     w_nxt_cnt   = r_cnt - CW'(1);
            end
            S_STOPPED: begin
                if (readout_done) begin
                    // A disarm seen now or earlier in STOPPED ends the sequence.
                    if (r_disarm_pend || disarm) begin
                        w_nxt_state = S_IDLE;
                    end else if (holdoff_cfg == '0) begin
                        w_nxt_state = S_ARMED;
                    end else begin
                        w_nxt_state = S_HOLDOFF;
                        w_nxt_cnt   = CW'(holdoff_cfg) - CW'(1);
                    end
                end else if (disarm) begin
                    w_nxt_pend = 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (disarm)              w_nxt_state = S_IDLE;
                else if (r_cnt == '0)    w_nxt_state = S_ARMED;
                else                     w_nxt_cnt   = r_cnt - CW'(1);
            end
            default: w_nxt_state = S_IDLE;
        endcase
        if (w_nxt_state == S_IDLE) w_nxt_pend = 1'b0;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_trig_d      <= 1'b0;
            r_disarm_pend <= 1'b0;
            r_sample_en   <= 1'b0;
            r_stop        <= 1'b0;
            r_busy        <= 1'b0;
            r_trig_count  <= '0;
        end else begin
            r_state       <= w_nxt_state;
            r_cnt         <= w_nxt_cnt;
            r_trig_d      <= trigger_sync;
            r_disarm_pend <= w_nxt_pend;
            r_sample_en   <= (w_nxt_state == S_ARMED) || (w_nxt_state == S_DELAY);
            r_stop        <= (w_nxt_state == S_STOPPED) && (r_state != S_STOPPED);
            r_busy        <= (w_nxt_state == S_DELAY) || (w_nxt_state == S_STOPPED) ||
                             (w_nxt_state == S_HOLDOFF);
            if (r_state == S_ARMED && !disarm && w_accept)
                r_trig_count <= r_trig_count + CNT_W'(1);
        end
    end

    assign sample_en  = r_sample_en;
    assign stop       = r_stop;
    assign busy       = r_busy;
    assign trig_count = r_trig_count;
    assign state      = r_state;

endmodule
